// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The sub wire is present only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             busy;

    modport master (
        output in_valid, x, y,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, busy
    );

    modport slave (
        input  in_valid, x, y,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH cycles per sum.
// Define SERIAL_ADD_SUB_EN to add the subtract mode (x - y via ~y + 1).
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_sum;

    logic             w_accept, w_last, w_s, w_cout, w_sub;
    logic [WIDTH-1:0] w_b_load;
    logic             w_in_ready, w_out_valid, w_busy;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is x + ~y + 1: invert B and seed the carry with 1.
    assign w_b_load = w_sub ? ~bus.y : bus.y;
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cout   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_RUN:   w_busy      = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_sum <= '0;
        end else if (w_accept) begin
            r_a   <= bus.x;
            r_b   <= w_b_load;
            r_c   <= w_sub;
            r_cnt <= '0;
            r_sum <= '0;
        end else if (r_state == S_RUN) begin
            // Sum bits enter at the top and walk down, so bit 0 ends up LSB.
            r_sum[WIDTH-1:0] <= {w_s, r_sum[WIDTH-1:1]};
            r_a              <= r_a >> 1;
            r_b              <= r_b >> 1;
            r_c              <= w_cout;
            if (w_last) r_sum[WIDTH] <= w_cout;
            else        r_cnt        <= r_cnt + CW'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
endmodule
